// File: rtl/seg_display_ctrl.sv
// Memory-mapped 8-digit seven-segment controller: hex or iterative binary-to-BCD
// digit buffer, scanned one digit at a time onto active-low anodes and a nibble bus.
module seg_display_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0010,
  parameter int unsigned SCAN_CYCLES = 262144
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_la_read,
  input  logic        mem_la_write,
  input  logic [31:0] mem_la_addr,
  input  logic [31:0] mem_la_wdata,
  input  logic [3:0]  mem_la_wstrb,
  output logic [31:0] rdata,
  output logic        rd_hit,
  output logic [7:0]  out_anode,
  output logic [3:0]  out_nibble,
  output logic        busy
);

  localparam int PW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(SCAN_CYCLES - 1);

  localparam logic [29:0] VALUE_WORD  = BASE_ADDR[31:2];
  localparam logic [29:0] CTRL_WORD   = BASE_ADDR[31:2] + 30'd1;
  localparam logic [29:0] STATUS_WORD = BASE_ADDR[31:2] + 30'd2;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} conv_state_t;

  conv_state_t state, state_next;
  logic        pending, pending_next;
  logic        busy_q, busy_next;

  logic [31:0] value_reg;
  logic        dec, en;
  logic [7:0]  mask;
  logic        ovf;

  logic [31:0] digit_buf;
  logic [31:0] shift_reg;
  logic [39:0] bcd, bcd_adj;
  logic [4:0]  iter;

  logic [PW-1:0] prescaler;
  logic [2:0]    digit_idx;

  logic        sel_value, sel_ctrl, sel_status;
  logic        wr_value, wr_ctrl, rd_sel;
  logic        dec_new, start, abort;
  logic [31:0] rd_mux;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^mem_la_addr[1:0];

  assign sel_value  = (mem_la_addr[31:2] == VALUE_WORD);
  assign sel_ctrl   = (mem_la_addr[31:2] == CTRL_WORD);
  assign sel_status = (mem_la_addr[31:2] == STATUS_WORD);

  assign wr_value = mem_la_write && sel_value;
  assign wr_ctrl  = mem_la_write && sel_ctrl;
  assign rd_sel   = mem_la_read && (sel_value || sel_ctrl || sel_status);

  // DEC as it will be after this edge decides between (re)starting and aborting
  assign dec_new = (wr_ctrl && mem_la_wstrb[0]) ? mem_la_wdata[0] : dec;
  assign start   = (wr_value || wr_ctrl) && dec_new;
  assign abort   = wr_ctrl && dec && !dec_new;

  assign busy = busy_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      value_reg <= 32'h0;
      dec       <= 1'b0;
      en        <= 1'b1;
      mask      <= 8'hFF;
    end else begin
      if (wr_value) begin
        for (int b = 0; b < 4; b++)
          if (mem_la_wstrb[b]) value_reg[8*b +: 8] <= mem_la_wdata[8*b +: 8];
      end
      if (wr_ctrl) begin
        if (mem_la_wstrb[0]) begin
          dec <= mem_la_wdata[0];
          en  <= mem_la_wdata[1];
        end
        if (mem_la_wstrb[1]) mask <= mem_la_wdata[15:8];
      end
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    if (sel_value)       rd_mux = value_reg;
    else if (sel_ctrl)   rd_mux = {16'h0, mask, 6'h0, en, dec};
    else if (sel_status) rd_mux = {30'h0, ovf, busy_q};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata  <= 32'h0;
      rd_hit <= 1'b0;
    end else begin
      rd_hit <= rd_sel;
      rdata  <= rd_sel ? rd_mux : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      pending <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      busy_q  <= busy_next;
    end
  end

  // COMMIT consumes the queued restart together with any write landing on the same edge
  always_comb begin
    state_next   = state;
    pending_next = pending;
    busy_next    = 1'b0;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        state_next = SHIFT;
        if (start) pending_next = 1'b1;
      end
      SHIFT: begin
        if (iter == 5'd31) state_next = COMMIT;
        if (start) pending_next = 1'b1;
      end
      COMMIT: begin
        state_next   = (pending || start) ? LOAD : IDLE;
        pending_next = 1'b0;
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next   = IDLE;
      pending_next = 1'b0;
    end
    busy_next = (state_next == SHIFT) || (state_next == COMMIT) ||
                (state == COMMIT && state_next == LOAD);
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 10; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      shift_reg <= 32'h0;
      bcd       <= 40'h0;
      iter      <= 5'd0;
      digit_buf <= 32'h0;
      ovf       <= 1'b0;
    end else begin
      if (state == LOAD) begin
        shift_reg <= value_reg;
        bcd       <= 40'h0;
        iter      <= 5'd0;
      end else if (state == SHIFT) begin
        bcd       <= {bcd_adj[38:0], shift_reg[31]};
        shift_reg <= {shift_reg[30:0], 1'b0};
        iter      <= iter + 5'd1;
      end
      // Hex mode mirrors VALUE continuously, which also covers the reload after an abort
      if (!dec) begin
        digit_buf <= value_reg;
      end else if (state == COMMIT && !abort) begin
        if (|bcd[39:32]) begin
          digit_buf <= 32'h9999_9999;
          ovf       <= 1'b1;
        end else begin
          digit_buf <= bcd[31:0];
          ovf       <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      prescaler  <= '0;
      digit_idx  <= 3'd0;
      out_anode  <= 8'hFF;
      out_nibble <= 4'h0;
    end else begin
      if (prescaler == PRESCALE_LAST) begin
        prescaler <= '0;
        digit_idx <= digit_idx + 3'd1;
      end else begin
        prescaler <= prescaler + PW'(1);
      end
      out_anode  <= (en && mask[digit_idx]) ? ~(8'd1 << digit_idx) : 8'hFF;
      out_nibble <= digit_buf[{digit_idx, 2'b00} +: 4];
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Randomized bench for seg_display_ctrl against a decimal/hex arithmetic reference
// model; digits are observed through the scanned out_nibble/out_anode outputs.
module tb_seg_display_ctrl;

  localparam logic [31:0] BASE = 32'h1000_0010;
  localparam int SCAN = 4;

  logic        clk;
  logic        resetn;
  logic        mem_la_read;
  logic        mem_la_write;
  logic [31:0] mem_la_addr;
  logic [31:0] mem_la_wdata;
  logic [3:0]  mem_la_wstrb;
  logic [31:0] rdata;
  logic        rd_hit;
  logic [7:0]  out_anode;
  logic [3:0]  out_nibble;
  logic        busy;

  seg_display_ctrl #(.BASE_ADDR(BASE), .SCAN_CYCLES(SCAN)) dut (
    .clk(clk), .resetn(resetn),
    .mem_la_read(mem_la_read), .mem_la_write(mem_la_write),
    .mem_la_addr(mem_la_addr), .mem_la_wdata(mem_la_wdata), .mem_la_wstrb(mem_la_wstrb),
    .rdata(rdata), .rd_hit(rd_hit),
    .out_anode(out_anode), .out_nibble(out_nibble), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; the scanned digit is a pure function of it
  int cyc;
  always @(posedge clk) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] m_value;
  logic        m_dec, m_en, m_ovf;
  logic [7:0]  m_mask;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic logic [31:0] to_bcd_digits(input logic [31:0] v);
    longint unsigned n;
    logic [31:0] r;
    n = longint'(v);
    r = 32'h0;
    if (n > 64'd99999999) return 32'h9999_9999;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] expected_buf();
    return m_dec ? to_bcd_digits(m_value) : m_value;
  endfunction

  function automatic logic [7:0] expected_anode(input int idx);
    if (m_en && m_mask[idx]) return 8'hFF ^ (8'd1 << idx);
    return 8'hFF;
  endfunction

  // One bus write, driven after a negedge and returning at the negedge after the write edge
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    mem_la_write = 1'b1;
    mem_la_addr  = addr;
    mem_la_wdata = data;
    mem_la_wstrb = strb;
    @(negedge clk);
    mem_la_write = 1'b0;
    mem_la_wstrb = 4'h0;
    if (addr[31:2] == BASE[31:2]) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_value[8*b +: 8] = data[8*b +: 8];
    end else if (addr[31:2] == BASE[31:2] + 30'd1) begin
      if (strb[0]) begin
        m_dec = data[0];
        m_en  = data[1];
      end
      if (strb[1]) m_mask = data[15:8];
    end
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_hit);
    mem_la_read = 1'b1;
    mem_la_addr = addr;
    @(negedge clk);
    mem_la_read = 1'b0;
    checkOutput(tag, rdata, exp_data);
    checkOutput({tag, "_hit"}, 32'(rd_hit), 32'(exp_hit));
    @(negedge clk);
    checkOutput({tag, "_hit_clear"}, 32'(rd_hit), 32'h0);
  endtask

  // Outputs after edge k show the digit selected after edge k-1
  task automatic check_scan(input int ncyc, input logic [31:0] exp_buf);
    int idx;
    for (int n = 0; n < ncyc; n++) begin
      idx = ((cyc - 1) / SCAN) % 8;
      checkOutput("nibble", 32'(out_nibble), 32'(exp_buf[4*idx +: 4]));
      checkOutput("anode", 32'(out_anode), 32'(expected_anode(idx)));
      @(negedge clk);
    end
  endtask

  // Write at edge N: busy must be high exactly for N+1..N+33
  task automatic decimal_write(input logic [31:0] v);
    applyStimulus(BASE, v, 4'hF);
    checkOutput("busy_at_write", 32'(busy), 32'h0);
    for (int rel = 1; rel <= 34; rel++) begin
      @(negedge clk);
      checkOutput("busy_conv", 32'(busy), 32'(rel <= 33));
    end
    m_ovf = (longint'(m_value) > 64'd99999999);
    read_check("status", BASE + 32'd8, {30'h0, m_ovf, 1'b0}, 1'b1);
    check_scan(32, expected_buf());
  endtask

  logic [31:0] rv;
  logic [3:0]  rs;
  logic [31:0] table_vals [4] = '{32'd100000000, 32'd5, 32'd99999999, 32'd0};

  initial begin
    resetn = 1'b0;
    mem_la_read = 1'b0;
    mem_la_write = 1'b0;
    mem_la_addr = 32'h0;
    mem_la_wdata = 32'h0;
    mem_la_wstrb = 4'h0;
    m_value = 32'h0;
    m_dec = 1'b0;
    m_en = 1'b1;
    m_mask = 8'hFF;
    m_ovf = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_anode", 32'(out_anode), 32'hFF);
    checkOutput("rst_nibble", 32'(out_nibble), 32'h0);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_rd_hit", 32'(rd_hit), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("first_anode", 32'(out_anode), 32'hFE);
    check_scan(40, 32'h0);
    read_check("rst_ctrl", BASE + 32'd4, 32'h0000_FF02, 1'b1);
    read_check("rst_value", BASE, 32'h0, 1'b1);
    read_check("rst_status", BASE + 32'd8, 32'h0, 1'b1);

    $display("[TB] hex mode");
    applyStimulus(BASE, 32'h1234_ABCD, 4'hF);
    repeat (2) @(negedge clk);
    checkOutput("hex_busy", 32'(busy), 32'h0);
    check_scan(32, 32'h1234_ABCD);

    $display("[TB] decimal mode");
    applyStimulus(BASE + 32'd4, 32'h0000_FF03, 4'hF);
    for (int rel = 1; rel <= 34; rel++) begin
      @(negedge clk);
      checkOutput("busy_ctrl_start", 32'(busy), 32'(rel <= 33));
    end
    m_ovf = 1'b1;
    read_check("status_ovf", BASE + 32'd8, 32'h2, 1'b1);
    check_scan(32, 32'h9999_9999);
    decimal_write(32'd12345678);
    foreach (table_vals[i]) decimal_write(table_vals[i]);
    for (int t = 0; t < 6; t++) begin
      rv = (t % 2 == 0) ? $urandom_range(0, 99999999) : $urandom;
      decimal_write(rv);
    end

    $display("[TB] restart while converting");
    applyStimulus(BASE, 32'd111, 4'hF);
    for (int rel = 1; rel <= 69; rel++) begin
      if (rel == 10)      applyStimulus(BASE, 32'd222, 4'hF);
      else if (rel == 20) applyStimulus(BASE, 32'd333, 4'hF);
      else                @(negedge clk);
      checkOutput("busy_restart", 32'(busy), 32'(rel <= 67));
    end
    m_ovf = 1'b0;
    read_check("status_restart", BASE + 32'd8, 32'h0, 1'b1);
    check_scan(32, to_bcd_digits(32'd333));

    $display("[TB] abort to hex");
    applyStimulus(BASE + 32'd4, 32'h0000_FF03, 4'hF);
    for (int rel = 1; rel <= 4; rel++) begin
      @(negedge clk);
      checkOutput("busy_pre_abort", 32'(busy), 32'h1);
    end
    applyStimulus(BASE + 32'd4, 32'h0000_FF02, 4'hF);
    checkOutput("busy_abort", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);
    check_scan(32, m_value);
    read_check("status_abort", BASE + 32'd8, {30'h0, m_ovf, 1'b0}, 1'b1);

    $display("[TB] byte strobes");
    applyStimulus(BASE, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(BASE, 32'h0000_5500, 4'b0010);
    read_check("value_strb", BASE, 32'hFFFF_55FF, 1'b1);
    for (int t = 0; t < 4; t++) begin
      rv = $urandom;
      rs = 4'($urandom_range(1, 15));
      applyStimulus(BASE, rv, rs);
      repeat (2) @(negedge clk);
      check_scan(32, m_value);
      read_check("value_rand", BASE, m_value, 1'b1);
    end

    $display("[TB] ignored accesses");
    applyStimulus(BASE + 32'd8, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(BASE + 32'd12, 32'h1111_1111, 4'hF);
    applyStimulus(BASE - 32'd4, 32'h2222_2222, 4'hF);
    read_check("status_ro", BASE + 32'd8, {30'h0, m_ovf, 1'b0}, 1'b1);
    read_check("value_kept", BASE, m_value, 1'b1);
    read_check("outside", BASE + 32'd12, 32'h0, 1'b0);

    $display("[TB] mask and enable");
    applyStimulus(BASE + 32'd4, 32'h0000_0F02, 4'hF);
    repeat (2) @(negedge clk);
    check_scan(32, m_value);
    applyStimulus(BASE + 32'd4, 32'h0000_0F00, 4'hF);
    repeat (2) @(negedge clk);
    check_scan(32, m_value);
    read_check("ctrl_mask", BASE + 32'd4, 32'h0000_0F00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not complete, got no summary, expected one");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Memory-mapped controller for the 8-digit seven-segment display, attached to the PicoRV32 look-ahead memory bus beside the on-chip RAM. Firmware writes a 32-bit value and a control word. The block performs an iterative binary-to-BCD conversion when decimal mode is selected and keeps a double-buffered digit store. It time-multiplexes one digit at a time onto the anode/nibble outputs that feed the cathode decoder.

## Interface
Parameters:
- BASE_ADDR, 32'h1000_0010: word-aligned base of the 3-register window.
- SCAN_CYCLES, 262144: clk cycles each digit stays selected; legal range 2 to 2^24.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- mem_la_read  in  1  look-ahead read strobe.
- mem_la_write  in  1  look-ahead write strobe.
- mem_la_addr  in  32  look-ahead byte address.
- mem_la_wdata  in  32  write data.
- mem_la_wstrb  in  4  byte strobes.
- rdata  out  32  registered read data.
- rd_hit  out  1  high one cycle after a read that hit the window; the system mux selects rdata when set.
- out_anode  out  8  active-low digit select; bit i selects digit i.
- out_nibble  out  4  value for the currently selected digit.
- busy  out  1  BCD conversion in progress.

## Operation
- Registers, at byte offsets from BASE_ADDR:
  - VALUE (+0): read/write; byte strobes honoured.
  - CTRL (+4): read/write. bit0 = DEC (1 decimal, 0 hex); bit1 = EN; bits[15:8] = MASK (per-digit enable); other bits read 0.
  - STATUS (+8): read-only. bit0 = busy; bit1 = OVF, set when the last decimal conversion saw a value > 99_999_999.
- Writes to STATUS, and accesses to addresses outside the window, are ignored.
- Hex mode: the digit buffer is loaded with VALUE directly (digit i = VALUE[4i+3:4i]). busy stays 0.
- Decimal mode: a write to VALUE or CTRL, or a 0→1 change of DEC, starts a conversion.
- Conversion FSM, states IDLE → LOAD → SHIFT → COMMIT → IDLE:
  - LOAD: copy VALUE to the shift register and clear the 40-bit BCD accumulator.
  - SHIFT: 32 iterations of double-dabble (add 3 to any BCD nibble ≥ 5, then shift left one bit).
  - COMMIT: write the low 8 BCD digits to the buffer. If any of BCD digits 8–9 is nonzero, write all-9s instead and set OVF; otherwise clear OVF.
- Write during LOAD/SHIFT/COMMIT: VALUE updates immediately and a pending flag is set. COMMIT still writes the stale result. The FSM then goes to LOAD, not IDLE. Only one restart is queued, regardless of how many writes occur.
- Switching DEC 1→0 mid-conversion aborts to IDLE. The buffer reloads from VALUE in hex form and busy clears.
- Scanner:
  - A prescaler counts 0..SCAN_CYCLES-1. On terminal count it wraps to 0 and the digit index (3 bits) increments, wrapping 7→0.
  - The scanner runs regardless of EN.
- Outputs:
  - out_anode = ~(1<<index) when EN=1 and MASK[index]=1; otherwise 8'hFF.
  - out_nibble = buffer digit[index].

## Timing
- Reset values:
  - out_anode 8'hFF, out_nibble 0, rdata 0, rd_hit 0, busy 0.
  - VALUE 0, CTRL 32'h0000_FF02 (hex, enabled, all digits), OVF 0.
  - Buffer 0, prescaler 0, index 0, FSM IDLE, pending 0.
- Reset mid-conversion returns everything to the reset values on the next edge.
- Register write: takes effect at the edge where mem_la_write is sampled.
- Register read: rdata and rd_hit are valid at the edge after mem_la_read is sampled. They are held for one cycle only; rd_hit returns to 0 afterwards.
- Hex mode: the buffer updates one edge after the VALUE write.
- Decimal mode, write at edge N: busy=1 from edge N+1 (LOAD); SHIFT at edges N+2..N+33; buffer and OVF update and busy=0 at edge N+34.
- out_anode/out_nibble are registered. They reflect index/buffer/CTRL changes one edge later, and a buffer change is visible mid-dwell.
- Simultaneous write and scan advance: both take effect; no ordering hazard.

## Test plan
- Reset then idle: out_anode=FF for one cycle, then FE. After SCAN_CYCLES=4 cycles it becomes FD; after 8 dwells it wraps back to FE.
- Hex mode, write VALUE=32'h1234_ABCD, SCAN_CYCLES=4: over 8 dwells out_nibble reads D,C,B,A,4,3,2,1 and busy stays 0.
- Decimal mode, write 12345678 at edge N: busy is high during N+1..N+33. At N+34 the buffer digits are 8,7,6,5,4,3,2,1 and STATUS reads 0.
- Decimal mode, write 100000000: buffer is all 9s and STATUS=2. A following write of 5 gives digits 5,0,0,0,0,0,0,0 and STATUS=0.
- Write 111, then 222 at N+10: busy stays high continuously until N+68, and the final buffer shows 222.
- CTRL MASK=8'h0F, then EN=0: anodes FE..F7, then FF for indices 4–7. EN=0 forces FF throughout. A read of CTRL returns 32'h0000_0F00 with rd_hit pulsing for one cycle.
